pipelined_cla_addsub: RTL and testbench

PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

---
 rtl/pipelined_cla_addsub_pkg.sv | 17 +
 rtl/cla_block_p.sv | 52 +++++
 rtl/pipelined_cla_addsub.sv | 172 +++++++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_cla_addsub_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor:
// operation encodings, default geometry and the carry-in mapping helper.
package pipelined_cla_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_BLOCK = 8;

    // Subtraction is x + ~y + !borrow_in, so the borrow input is inverted
    // to become the adder carry-in.
    function automatic logic effective_carry(input logic op_bit, input logic c_bit);
        effective_carry = (op_bit == OP_SUB) ? ~c_bit : c_bit;
    endfunction

endpackage

// File: rtl/cla_block_p.sv
// One carry-lookahead block: group propagate/generate of the block and the
// in-block sum bits for a given block carry-in. Every carry is a flat
// sum-of-products of the block inputs, so there is no ripple chain.
module cla_block_p
    import pipelined_cla_addsub_pkg::*;
#(
    parameter int BLOCK = DEFAULT_BLOCK
) (
    input  logic [BLOCK-1:0] p,
    input  logic [BLOCK-1:0] g,
    input  logic             c_blk_in,
    output logic             grp_p,
    output logic             grp_g,
    output logic [BLOCK-1:0] sum
);

    logic [BLOCK:0]   gen_s;
    logic [BLOCK-1:0] pre_p_s;
    logic [BLOCK-1:0] carry_s;
    logic             term_s;

    // Prefix generate (carry out of bits 0..i-1 with zero carry-in) and prefix propagate.
    always_comb begin
        gen_s   = '0;
        pre_p_s = '0;
        term_s  = 1'b0;
        for (int i = 0; i <= BLOCK; i++) begin
            for (int j = 0; j < i; j++) begin
                term_s = g[j];
                for (int m = j + 1; m < i; m++) begin
                    term_s = term_s & p[m];
                end
                gen_s[i] = gen_s[i] | term_s;
            end
        end
        for (int i = 0; i < BLOCK; i++) begin
            pre_p_s[i] = 1'b1;
            for (int m = 0; m < i; m++) begin
                pre_p_s[i] = pre_p_s[i] & p[m];
            end
        end
    end

    // In-block carries from the block carry-in, and the block outputs.
    always_comb begin
        carry_s = gen_s[BLOCK-1:0] | ({BLOCK{c_blk_in}} & pre_p_s);
        sum     = p ^ carry_s;
        grp_p   = &p;
        grp_g   = gen_s[BLOCK];
    end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshakes. S1 registers bit and block propagate/generate terms; S2 does
// the block-level lookahead, forms the sum and flags, and holds them while
// the consumer stalls.
module pipelined_cla_addsub
    import pipelined_cla_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int BLOCK = DEFAULT_BLOCK
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             op,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NUM_BLOCKS = WIDTH / BLOCK;

    // S1 front-end (combinational)
    logic [WIDTH-1:0]      yy_s;
    logic [WIDTH-1:0]      p_s;
    logic [WIDTH-1:0]      g_s;
    logic                  ci_s;
    logic [NUM_BLOCKS-1:0] bp_s;
    logic [NUM_BLOCKS-1:0] bg_s;
    logic                  pg_term_s;

    // S1 registers
    logic                  s1_valid_r;
    logic [WIDTH-1:0]      s1_p_r;
    logic [WIDTH-1:0]      s1_g_r;
    logic                  s1_ci_r;
    logic [NUM_BLOCKS-1:0] s1_bp_r;
    logic [NUM_BLOCKS-1:0] s1_bg_r;

    // S2 datapath and handshake
    logic [NUM_BLOCKS:0]   blk_c_s;
    logic                  blk_term_s;
    logic [WIDTH-1:0]      sum_s;
    logic                  ovf_s;
    logic [NUM_BLOCKS-1:0] grp_p_unused_s;
    logic [NUM_BLOCKS-1:0] grp_g_unused_s;
    logic                  s2_load_s;
    logic                  take_s;

    // S2 can accept new data when it is empty or its result is being handed off.
    assign s2_load_s = ~out_valid | out_ready;
    assign in_ready  = ~s1_valid_r | s2_load_s;
    assign take_s    = in_valid & in_ready;

    // Effective operand, carry-in and per-bit propagate/generate.
    always_comb begin
        yy_s = (op == OP_SUB) ? ~y : y;
        ci_s = effective_carry(op, c_in);
        p_s  = x ^ yy_s;
        g_s  = x & yy_s;
    end

    // Per-block group propagate/generate, flat lookahead within each block.
    always_comb begin
        bp_s      = '0;
        bg_s      = '0;
        pg_term_s = 1'b0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            bp_s[k] = &p_s[k*BLOCK +: BLOCK];
            for (int j = 0; j < BLOCK; j++) begin
                pg_term_s = g_s[k*BLOCK + j];
                for (int m = j + 1; m < BLOCK; m++) begin
                    pg_term_s = pg_term_s & p_s[k*BLOCK + m];
                end
                bg_s[k] = bg_s[k] | pg_term_s;
            end
        end
    end

    // S1 occupancy: fill on acceptance, empty when its contents move on to S2.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
        end else if (take_s) begin
            s1_valid_r <= 1'b1;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // S1 data: operands are sampled only on an input transfer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_p_r  <= '0;
            s1_g_r  <= '0;
            s1_ci_r <= 1'b0;
            s1_bp_r <= '0;
            s1_bg_r <= '0;
        end else if (take_s) begin
            s1_p_r  <= p_s;
            s1_g_r  <= g_s;
            s1_ci_r <= ci_s;
            s1_bp_r <= bp_s;
            s1_bg_r <= bg_s;
        end
    end

    // Block carry-ins: c[k] expanded as a flat sum-of-products of G/P and ci.
    always_comb begin
        blk_c_s    = '0;
        blk_term_s = 1'b0;
        blk_c_s[0] = s1_ci_r;
        for (int k = 1; k <= NUM_BLOCKS; k++) begin
            blk_term_s = s1_ci_r;
            for (int m = 0; m < k; m++) begin
                blk_term_s = blk_term_s & s1_bp_r[m];
            end
            blk_c_s[k] = blk_term_s;
            for (int j = 0; j < k; j++) begin
                blk_term_s = s1_bg_r[j];
                for (int m = j + 1; m < k; m++) begin
                    blk_term_s = blk_term_s & s1_bp_r[m];
                end
                blk_c_s[k] = blk_c_s[k] | blk_term_s;
            end
        end
    end

    // The instances also recompute group P/G from the registered bits; the
    // lookahead above uses the copies captured in S1 instead.
    for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_blk
        cla_block_p #(
            .BLOCK(BLOCK)
        ) u_blk (
            .p        (s1_p_r[k*BLOCK +: BLOCK]),
            .g        (s1_g_r[k*BLOCK +: BLOCK]),
            .c_blk_in (blk_c_s[k]),
            .grp_p    (grp_p_unused_s[k]),
            .grp_g    (grp_g_unused_s[k]),
            .sum      (sum_s[k*BLOCK +: BLOCK])
        );
    end

    // Carry into the MSB is recovered as p ^ s at that bit.
    assign ovf_s = s1_p_r[WIDTH-1] ^ sum_s[WIDTH-1] ^ blk_c_s[NUM_BLOCKS];

    // S2 result registers: load when S2 is free, otherwise hold for the consumer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (s2_load_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                s     <= sum_s;
                c_out <= blk_c_s[NUM_BLOCKS];
                ovf   <= ovf_s;
                zero  <= ~|sum_s;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: directed 32-bit vectors, stall and
// mid-stream reset sequences, and a 16-bit/4-bit-block random run against
// a reference model.
module tb_pipelined_cla_addsub;
    import pipelined_cla_addsub_pkg::*;

    typedef struct packed {
        logic        op;
        logic [31:0] x;
        logic [31:0] y;
        logic        c_in;
        logic [31:0] s;
        logic        c_out;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic clock;
    logic reset_n;

    logic        in_valid_a, in_ready_a, op_a, c_in_a, out_valid_a, out_ready_a;
    logic [31:0] x_a, y_a, s_a;
    logic        c_out_a, ovf_a, zero_a;

    logic        in_valid_b, in_ready_b, op_b, c_in_b, out_valid_b, out_ready_b;
    logic [15:0] x_b, y_b, s_b;
    logic        c_out_b, ovf_b, zero_b;

    int tests = 0;
    int fails = 0;

    vec_t vecs[12];
    vec_t st[4];
    logic [34:0] got[4];

    pipelined_cla_addsub #(.WIDTH(32), .BLOCK(8)) u_dut_a (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .x(x_a), .y(y_a), .op(op_a), .c_in(c_in_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .s(s_a), .c_out(c_out_a), .ovf(ovf_a), .zero(zero_a)
    );

    pipelined_cla_addsub #(.WIDTH(16), .BLOCK(4)) u_dut_b (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .x(x_b), .y(y_b), .op(op_b), .c_in(c_in_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .s(s_b), .c_out(c_out_b), .ovf(ovf_b), .zero(zero_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic vec_t mk(input logic o, input logic [31:0] a, input logic [31:0] b,
                                input logic ci, input logic [31:0] r, input logic co,
                                input logic ov, input logic z);
        vec_t v;
        v.op = o; v.x = a; v.y = b; v.c_in = ci;
        v.s = r; v.c_out = co; v.ovf = ov; v.zero = z;
        return v;
    endfunction

    // Reference for the 16-bit instance: {s, c_out, ovf, zero}.
    function automatic logic [18:0] model16(input logic o, input logic [15:0] a,
                                            input logic [15:0] b, input logic ci);
        logic [15:0] bb;
        logic [16:0] full;
        logic        v;
        bb   = o ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'h0000, (o ? ~ci : ci)};
        v    = (a[15] == bb[15]) && (full[15] != a[15]);
        return {full[15:0], full[16], v, (full[15:0] == 16'h0000)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        op_a = v.op; x_a = v.x; y_a = v.y; c_in_a = v.c_in;
        in_valid_a = 1'b1; out_ready_a = 1'b1;
        #1;
        check({name, "_in_ready"}, 64'(in_ready_a), 64'(1'b1));
        @(posedge clock); #1;
        in_valid_a = 1'b0;
        check({name, "_lat1"}, 64'(out_valid_a), 64'(1'b0));
        @(posedge clock); #1;
        check({name, "_valid"}, 64'(out_valid_a), 64'(1'b1));
        check({name, "_result"}, 64'({s_a, c_out_a, ovf_a, zero_a}),
              64'({v.s, v.c_out, v.ovf, v.zero}));
        @(posedge clock); #1;
        check({name, "_drained"}, 64'(out_valid_a), 64'(1'b0));
    endtask

    initial begin
        int acc;
        int n;
        int last_cyc;
        int rcyc;
        logic [18:0] q[$];

        reset_n = 1'b1;
        in_valid_a = 1'b0; op_a = 1'b0; x_a = 32'h0; y_a = 32'h0; c_in_a = 1'b0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; op_b = 1'b0; x_b = 16'h0; y_b = 16'h0; c_in_b = 1'b0; out_ready_b = 1'b1;

        vecs[0]  = mk(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        vecs[1]  = mk(OP_SUB, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        vecs[2]  = mk(OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        vecs[4]  = mk(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        vecs[5]  = mk(OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        vecs[6]  = mk(OP_ADD, 32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_999A, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(OP_SUB, 32'h0000_0010, 32'h0000_0003, 1'b1, 32'h0000_000C, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        vecs[9]  = mk(OP_SUB, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(OP_ADD, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(OP_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        st[0] = mk(OP_ADD, 32'd1,  32'd1, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        st[1] = mk(OP_ADD, 32'd3,  32'd4, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        st[2] = mk(OP_SUB, 32'd10, 32'd4, 1'b0, 32'h0000_0006, 1'b1, 1'b0, 1'b0);
        st[3] = mk(OP_SUB, 32'd2,  32'd3, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // Power-on reset
        #3 reset_n = 1'b0;
        #1;
        check("rst_in_ready_low", 64'(in_ready_a), 64'(1'b1));
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 64'(out_valid_a), 64'(1'b0));
        check("rst_outputs", 64'({s_a, c_out_a, ovf_a, zero_a}), 64'(0));
        check("rst_in_ready_b", 64'(in_ready_b), 64'(1'b1));
        check("rst_out_valid_b", 64'(out_valid_b), 64'(1'b0));
        reset_n = 1'b1;

        // Directed vectors; the first is offered on the first edge after release
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back stream with the consumer stalled for three cycles
        acc = 0; n = 0; last_cyc = 0;
        for (int cyc = 1; cyc <= 20 && n < 4; cyc++) begin
            out_ready_a = !(cyc >= 3 && cyc <= 5);
            if (acc < 4) begin
                in_valid_a = 1'b1;
                op_a = st[acc].op; x_a = st[acc].x; y_a = st[acc].y; c_in_a = st[acc].c_in;
                if (cyc == 4) begin
                    x_a = 32'hDEAD_BEEF; y_a = 32'h1234_5678; op_a = ~op_a;
                end
            end else begin
                in_valid_a = 1'b0;
            end
            #1;
            if (cyc == 3) begin
                check("stall_in_ready", 64'(in_ready_a), 64'(1'b0));
                check("stall_accepts", 64'(acc), 64'(2));
            end
            if (cyc >= 3 && cyc <= 5) begin
                check("stall_hold_valid", 64'(out_valid_a), 64'(1'b1));
                check("stall_hold_data", 64'({s_a, c_out_a, ovf_a, zero_a}),
                      64'({st[0].s, st[0].c_out, st[0].ovf, st[0].zero}));
            end
            if (out_valid_a && out_ready_a) begin
                got[n] = {s_a, c_out_a, ovf_a, zero_a};
                n++;
                last_cyc = cyc;
            end
            if (in_valid_a && in_ready_a) acc++;
            @(posedge clock); #1;
        end
        in_valid_a = 1'b0;
        out_ready_a = 1'b1;
        check("stall_count", 64'(n), 64'(4));
        check("stall_last_cycle", 64'(last_cyc), 64'(9));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall_order%0d", i), 64'(got[i]),
                  64'({st[i].s, st[i].c_out, st[i].ovf, st[i].zero}));
        end
        for (int i = 0; i < 3; i++) begin
            check("stall_no_dup", 64'(out_valid_a), 64'(1'b0));
            @(posedge clock); #1;
        end

        // Reset with two operations in flight
        out_ready_a = 1'b0;
        in_valid_a = 1'b1; op_a = OP_ADD; x_a = 32'd1; y_a = 32'd2; c_in_a = 1'b0;
        @(posedge clock); #1;
        x_a = 32'd5; y_a = 32'd6;
        @(posedge clock); #1;
        in_valid_a = 1'b0;
        check("flight_valid", 64'(out_valid_a), 64'(1'b1));
        check("flight_s", 64'({s_a, c_out_a, ovf_a, zero_a}), 64'({32'd3, 3'b000}));
        reset_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(out_valid_a), 64'(1'b0));
        check("rst_mid_outputs", 64'({s_a, c_out_a, ovf_a, zero_a}), 64'(0));
        check("rst_mid_in_ready", 64'(in_ready_a), 64'(1'b1));
        @(posedge clock); #1;
        check("rst_hold_in_ready", 64'(in_ready_a), 64'(1'b1));
        reset_n = 1'b1;
        out_ready_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check("rst_no_stale", 64'(out_valid_a), 64'(1'b0));
        end
        run_vec(vecs[6], "post_rst");

        // Random traffic on the 16-bit instance with random backpressure
        acc = 0; rcyc = 0;
        while (acc < 10000 && rcyc < 60000) begin
            in_valid_b  = ($urandom_range(0, 9) < 8);
            op_b        = 1'($urandom_range(0, 1));
            c_in_b      = 1'($urandom_range(0, 1));
            x_b         = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            y_b         = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            out_ready_b = ($urandom_range(0, 9) < 7);
            #1;
            if (out_valid_b) begin
                if (q.size() == 0) begin
                    check("rnd_spurious", 64'(1'b1), 64'(1'b0));
                end else begin
                    check("rnd_out", 64'({s_b, c_out_b, ovf_b, zero_b}), 64'(q[0]));
                    if (out_ready_b) void'(q.pop_front());
                end
            end
            if (in_valid_b && in_ready_b) begin
                q.push_back(model16(op_b, x_b, y_b, c_in_b));
                acc++;
            end
            @(posedge clock); #1;
            rcyc++;
        end
        in_valid_b = 1'b0;
        out_ready_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid_b) begin
                if (q.size() == 0) begin
                    check("rnd_spurious", 64'(1'b1), 64'(1'b0));
                end else begin
                    check("rnd_out", 64'({s_b, c_out_b, ovf_b, zero_b}), 64'(q[0]));
                    void'(q.pop_front());
                end
            end
            @(posedge clock); #1;
        end
        check("rnd_accepts", 64'(acc), 64'(10000));
        check("rnd_drain", 64'(q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
